// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe elastic register pipeline.
// Default geometry plus the occupancy counter width function.
package reg_pipe_pkg;

  localparam int WL_DEF    = 8;
  localparam int DEPTH_DEF = 3;

  function automatic int cw_f(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic pipeline slot: data + valid register with ready chaining.
// Data only loads on a valid incoming word, so it holds across bubbles.
module reg_pipe_stage #(
  parameter int             WL      = 8,
  parameter logic [WL-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [WL-1:0] d_in,
  input  logic          v_in,
  input  logic          ready_nxt,
  output logic [WL-1:0] d,
  output logic          v,
  output logic          v_nxt,
  output logic          ready
);

  assign ready = !v | ready_nxt;

  always_comb begin
    v_nxt = v;
    if (!rst || flush)
      v_nxt = 1'b0;
    else if (ready)
      v_nxt = v_in;
  end

  always_ff @(posedge clk) begin
    v <= v_nxt;
    if (!rst)
      d <= RST_VAL;
    else if (!flush && ready && v_in)
      d <= d_in;
  end

endmodule

// File: rtl/reg_pipe.sv
// Elastic valid/ready register pipeline of DEPTH stages.
// Ready ripples back combinationally; data and valid move forward registered.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int            WL      = WL_DEF,
  parameter int            DEPTH   = DEPTH_DEF,
  parameter logic [WL-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic signed [WL-1:0]       in,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [WL-1:0]       out,
  input  logic                       out_ready,
  output logic [cw_f(DEPTH)-1:0]     count
);

  localparam int CW = cw_f(DEPTH);

  // Index 0 is the upstream port; index i+1 is the output of stage i.
  logic [WL-1:0]  dch [DEPTH+1];
  logic           vch [DEPTH+1];
  logic           rdy [DEPTH+1];
  logic [DEPTH-1:0] vn;
  logic [CW-1:0]  cnt_n;

  assign dch[0]     = in;
  assign vch[0]     = in_valid;
  assign rdy[DEPTH] = out_ready;

  assign in_ready  = rdy[0] & !flush;
  assign out       = dch[DEPTH];
  assign out_valid = vch[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    reg_pipe_stage #(
      .WL      (WL),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .d_in      (dch[i]),
      .v_in      (vch[i]),
      .ready_nxt (rdy[i+1]),
      .d         (dch[i+1]),
      .v         (vch[i+1]),
      .v_nxt     (vn[i]),
      .ready     (rdy[i])
    );
  end

  always_comb begin
    cnt_n = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_n = cnt_n + CW'(vn[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else
      count <= cnt_n;
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: directed scenarios plus random traffic.
// Expected values come from a slot/hole model of the pipe kept here.
module tb_reg_pipe;

  localparam int D  = 3;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in = '0;
  logic              in_ready;
  logic              out_valid;
  logic signed [7:0] out;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  reg_pipe #(
    .WL      (8),
    .DEPTH   (D),
    .RST_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in        (in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out),
    .out_ready (out_ready),
    .count     (count)
  );

  int total  = 0;
  int passed = 0;

  // Model: slot D-1 is the output slot.
  bit         mv [D];
  logic [7:0] md [D];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // A slot can take a word if some slot at or after it is empty,
  // or if the consumer is draining the output.
  function automatic bit can_move(int i, bit ordy);
    bit r;
    r = ordy;
    for (int j = i; j < D; j++)
      if (!mv[j]) r = 1'b1;
    return r;
  endfunction

  task automatic step(bit iv, logic [7:0] id, bit ordy,
                      bit fl, bit rs, bit crdy);
    bit         r  [D];
    bit         ov [D];
    logic [7:0] od [D];
    int         c;
    @(negedge clk);
    in_valid  = iv;
    in        = id;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    for (int i = 0; i < D; i++) r[i] = can_move(i, ordy);
    if (crdy) chk("in_ready", {31'h0, in_ready}, {31'h0, r[0] && !fl});
    @(posedge clk);
    ov = mv;
    od = md;
    if (!rs) begin
      for (int i = 0; i < D; i++) begin
        mv[i] = 1'b0;
        md[i] = 8'h00;
      end
    end else if (fl) begin
      for (int i = 0; i < D; i++) mv[i] = 1'b0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (r[i]) begin
          if (i == 0) begin
            mv[0] = iv;
            if (iv) md[0] = id;
          end else begin
            mv[i] = ov[i-1];
            if (ov[i-1]) md[i] = od[i-1];
          end
        end
      end
    end
    c = 0;
    for (int i = 0; i < D; i++) c += int'(mv[i]);
    #1;
    chk("out_valid", {31'h0, out_valid}, {31'h0, mv[D-1]});
    chk("out", {24'h0, out}, {24'h0, md[D-1]});
    chk("count", {30'h0, count}, 32'(c));
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      md[i] = 8'h00;
    end

    // Reset with a word offered: nothing may be captured.
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_out", {24'h0, out}, 32'h0);
    chk("rst_ov", {31'h0, out_valid}, 32'h0);
    chk("rst_cnt", {30'h0, count}, 32'h0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

    // Latency of a single word through an empty pipe.
    step(1'b1, 8'hFB, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("lat_out", {24'h0, out}, 32'hFB);
    chk("lat_ov", {31'h0, out_valid}, 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("lat_ov_off", {31'h0, out_valid}, 32'h0);

    // Backpressure then release.
    step(1'b1, 8'd10, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd20, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd30, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_cnt", {30'h0, count}, 32'd3);
    chk("bp_out", {24'h0, out}, 32'd10);
    step(1'b1, 8'd40, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_hold", {24'h0, out}, 32'd10);
    step(1'b1, 8'd40, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("bp_o20", {24'h0, out}, 32'd20);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("bp_o30", {24'h0, out}, 32'd30);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("bp_o40", {24'h0, out}, 32'd40);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Full-rate streaming.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
      if (k >= 3) begin
        chk("st_out", {24'h0, out}, 32'(k - 2));
        chk("st_cnt", {30'h0, count}, 32'd3);
      end
    end
    for (int k = 0; k < 3; k++)
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Flush drops contents and the offered word, keeps data.
    step(1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd8, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd99, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("fl_cnt", {30'h0, count}, 32'd0);
    chk("fl_ov", {31'h0, out_valid}, 32'd0);
    chk("fl_out", {24'h0, out}, 32'd9);
    for (int k = 0; k < 4; k++)
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset while full and stalled, then normal operation.
    for (int k = 0; k < 3; k++)
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mr_out", {24'h0, out}, 32'h0);
    chk("mr_ov", {31'h0, out_valid}, 32'h0);
    chk("mr_cnt", {30'h0, count}, 32'h0);
    step(1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("mr_lat", {24'h0, out}, 32'h12);
    chk("mr_ov2", {31'h0, out_valid}, 32'h1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0),
           8'($urandom),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 49) != 0),
           1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
